// File: rtl/mandel_pkg.sv
// Types and constants shared by the zoom sequencer and the Mandelbrot renderer.
// Coordinates are signed Q4.28 fixed point.
package mandel_pkg;

  localparam int COORD_W = 32;
  localparam int FRAC_W  = 28;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    IDLE      = 2'd1,
    ISSUE     = 2'd2,
    WAIT_DONE = 2'd3
  } seq_state_e;

endpackage : mandel_pkg

// File: rtl/tick_sync.sv
// Two-flop synchroniser plus rising-edge detect for the slow tick square wave.
// Pulse is registered-only logic; 2-3 clk from async rise, no backpressure.
module tick_sync (
  input  logic clk,
  input  logic resetn,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Falling edges of the square wave are deliberately ignored.
  assign rise_pulse = sync_q & ~prev_q;

endmodule : tick_sync

// File: rtl/zoom_sequencer.sv
// Steps the Mandelbrot view one zoom level per tick and requests a frame over valid/ready.
// New view and frame_valid appear one clk after the tick event; ticks are dropped (counted) while a frame is outstanding.
module zoom_sequencer #(
  parameter int                 COORD_W = mandel_pkg::COORD_W,
  parameter int                 LEVELS  = 48,
  parameter int                 SHIFT   = 3,
  parameter logic [COORD_W-1:0] CX0     = 32'hF3D7_0A3D,
  parameter logic [COORD_W-1:0] CY0     = 32'h00A3_D70A,
  parameter logic [COORD_W-1:0] STEP0   = 32'h0100_0000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tick_in,
  input  logic               enable,
  output logic               frame_valid,
  input  logic               frame_ready,
  input  logic               render_done,
  output logic [COORD_W-1:0] center_x,
  output logic [COORD_W-1:0] center_y,
  output logic [COORD_W-1:0] step,
  output logic [5:0]         zoom_level,
  output logic [15:0]        dropped_cnt
);

  localparam logic [5:0] LAST_LEVEL = 6'(LEVELS - 1);

  logic tick_evt;

  tick_sync u_tick_sync (
    .clk        (clk),
    .resetn     (resetn),
    .async_in   (tick_in),
    .rise_pulse (tick_evt)
  );

  mandel_pkg::seq_state_e state_q, state_d;
  logic                   boot_arm_q;
  logic                   frame_valid_q, frame_valid_d;
  logic [5:0]             level_q, level_d;
  logic [COORD_W-1:0]     step_q, step_d;
  logic [15:0]            dropped_q, dropped_d;
  logic [COORD_W-1:0]     center_x_q, center_y_q;
  logic                   drop_evt;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    step_d    = step_q;
    dropped_d = dropped_q;
    drop_evt  = 1'b0;

    case (state_q)
      // Hold BOOT for one edge so the first request never races reset release.
      mandel_pkg::BOOT: begin
        if (boot_arm_q) begin
          state_d = mandel_pkg::ISSUE;
        end
      end
      mandel_pkg::IDLE: begin
        if (tick_evt && enable) begin
          state_d = mandel_pkg::ISSUE;
          if (level_q == LAST_LEVEL) begin
            level_d = 6'd0;
            step_d  = STEP0;
          end else begin
            level_d = level_q + 6'd1;
            step_d  = step_q - (step_q >> SHIFT);
          end
        end
      end
      mandel_pkg::ISSUE: begin
        drop_evt = tick_evt && enable;
        if (frame_valid_q && frame_ready) begin
          state_d = mandel_pkg::WAIT_DONE;
        end
      end
      mandel_pkg::WAIT_DONE: begin
        drop_evt = tick_evt && enable;
        if (render_done) begin
          state_d = mandel_pkg::IDLE;
        end
      end
      default: state_d = mandel_pkg::BOOT;
    endcase

    if (drop_evt && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end

    frame_valid_d = (state_d == mandel_pkg::ISSUE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= mandel_pkg::BOOT;
      boot_arm_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      level_q       <= 6'd0;
      step_q        <= STEP0;
      dropped_q     <= 16'd0;
      center_x_q    <= CX0;
      center_y_q    <= CY0;
    end else begin
      state_q       <= state_d;
      boot_arm_q    <= 1'b1;
      frame_valid_q <= frame_valid_d;
      level_q       <= level_d;
      step_q        <= step_d;
      dropped_q     <= dropped_d;
      center_x_q    <= CX0;
      center_y_q    <= CY0;
    end
  end

  assign frame_valid = frame_valid_q;
  assign center_x    = center_x_q;
  assign center_y    = center_y_q;
  assign step        = step_q;
  assign zoom_level  = level_q;
  assign dropped_cnt = dropped_q;

endmodule : zoom_sequencer
